// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the I-cache (requester 0)
// and the D-cache (requester 1); one latched line transaction at a time.
module cacheline_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned PRIO_INIT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic                  PRIO_RST  = (PRIO_INIT != 0) ? 1'b1 : 1'b0;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-5){1'b1}}, 5'b00000};

    state_e                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic                    gnt_q, gnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [LINE_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [LINE_WIDTH-1:0]   i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic                    i_resp_q, i_resp_d;
    logic                    d_resp_q, d_resp_d;

    logic                    i_act_s;
    logic                    d_act_s;
    logic                    sel_s;
    logic                    sel_wr_s;

    assign i_act_s = i_read | i_write;
    assign d_act_s = d_read | d_write;

    // Next-state and output-register logic for the IDLE/MEM/RESP transaction FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_resp_d    = 1'b0;
        d_resp_d    = 1'b0;
        sel_s       = 1'b0;
        sel_wr_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Pointer only matters on contention; otherwise the sole active side wins.
                if (i_act_s && d_act_s) begin
                    sel_s = ptr_q;
                end else begin
                    sel_s = d_act_s;
                end
                sel_wr_s = sel_s ? d_write : i_write;
                if (i_act_s || d_act_s) begin
                    gnt_d       = sel_s;
                    we_d        = sel_wr_s;
                    mem_addr_d  = (sel_s ? d_addr : i_addr) & LINE_MASK;
                    mem_wdata_d = sel_s ? d_wdata : i_wdata;
                    mem_write_d = sel_wr_s;
                    mem_read_d  = ~sel_wr_s;
                    ptr_d       = ~sel_s;
                    state_d     = ST_MEM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (gnt_q) begin
                        d_resp_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        i_resp_d = 1'b1;
                        if (!we_q) begin
                            i_rdata_d = mem_rdata;
                        end else begin
                            i_rdata_d = i_rdata_q;
                        end
                    end
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PRIO_RST;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_resp_q    <= i_resp_d;
            d_resp_q    <= d_resp_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_resp    = i_resp_q;
    assign d_resp    = d_resp_q;

endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Shares one cacheline-granularity memory port (256-bit line, 32-bit address) between two caches: requester 0 (I-cache miss port) and requester 1 (D-cache miss/writeback port).
- Sits between the caches' memory-side ports and the memory model / burst adapter.
- Uses round-robin arbitration and a registered 3-state FSM.
- Services exactly one line transaction at a time; latches the winning request so the memory-side outputs are stable for the whole transaction.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- LINE_WIDTH, 256, cacheline data width.
- PRIO_INIT, 1, requester favoured after reset (0 = I, 1 = D).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_addr  input  ADDR_WIDTH  requester 0 line address
- i_read  input  1  requester 0 read request (level, held until i_resp)
- i_write  input  1  requester 0 write request (level, held until i_resp)
- i_wdata  input  LINE_WIDTH  requester 0 write line
- i_rdata  output  LINE_WIDTH  requester 0 read line
- i_resp  output  1  requester 0 one-cycle completion pulse
- d_addr  input  ADDR_WIDTH  requester 1 line address
- d_read  input  1  requester 1 read request
- d_write  input  1  requester 1 write request
- d_wdata  input  LINE_WIDTH  requester 1 write line
- d_rdata  output  LINE_WIDTH  requester 1 read line
- d_resp  output  1  requester 1 completion pulse
- mem_addr  output  ADDR_WIDTH  memory line address, low 5 bits forced to 0
- mem_read  output  1  memory read strobe (level)
- mem_write  output  1  memory write strobe (level)
- mem_wdata  output  LINE_WIDTH  memory write line
- mem_rdata  input  LINE_WIDTH  memory read line
- mem_resp  input  1  memory completion pulse

Behaviour:
- Clock: single clock clk. Reset: rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - mem_addr = 0, mem_read = 0, mem_write = 0, mem_wdata = 0.
  - i_rdata = 0, d_rdata = 0, i_resp = 0, d_resp = 0.
  - state = IDLE; priority pointer = PRIO_INIT.
- A requester is active when its read|write is asserted. read and write both asserted on one requester is illegal; if it occurs, write wins.
- IDLE:
  - No active requester: stay in IDLE.
  - Exactly one active: grant it.
  - Both active: grant the requester named by the priority pointer.
  - On a grant, at the clock edge: latch grant id, addr (low 5 bits zeroed), read/write, wdata; drive mem_* from the latched values; flip the pointer to the non-granted requester; go to MEM.
  - mem_resp in IDLE is ignored.
- MEM:
  - mem_read/mem_write held constant; all mem_* stable.
  - Requester inputs are ignored; changes by the granted requester are not propagated.
  - On mem_resp, at the edge:
    - Deassert mem_read/mem_write.
    - On a read, capture mem_rdata into the granted requester's rdata register.
    - Assert the granted requester's resp.
    - Go to RESP.
  - Wait in MEM indefinitely if mem_resp never arrives.
- RESP: resp high for exactly this one cycle; next edge clears resp and returns to IDLE.
  - Arbitration resumes in IDLE, so the earliest next grant is 1 cycle after RESP.
  - A requester must drop or change its request on the edge where it samples resp.
- Latency: request seen in IDLE at cycle t → mem strobe visible at t+1. mem_resp at cycle m → requester resp at m+1.
- rdata hold: x_rdata holds its value until the next read completion to that requester. Writes leave rdata unchanged.
- Fairness: with both requesters continuously active, grants strictly alternate.
- Reset mid-transaction (MEM or RESP): all outputs return to reset values in the next cycle and the pointer returns to PRIO_INIT. The pending transaction is dropped and no resp is issued.

Test Plan:
- Single I read: i_read = 1, i_addr = 0x0000_1234; mem_resp 3 cycles after mem_read with mem_rdata = {8{32'hA5A5_0001}} → mem_addr = 0x0000_1220. One-cycle i_resp the cycle after mem_resp with i_rdata = that line. d_resp stays 0.
- Single D write: d_write = 1, d_addr = 0x8000_0040, d_wdata = {8{32'hDEAD_BEEF}} → mem_write = 1 with matching addr/wdata. d_resp pulses once. d_rdata unchanged.
- Simultaneous requests after reset (PRIO_INIT = 1): i_read and d_read held continuously → grant order D, I, D, I. Each resp is a single cycle. The two responses are never asserted together.
- Stability: in MEM, the granted requester changes addr to 0xFFFF_FFE0 mid-transaction → mem_addr and mem_wdata are unchanged until mem_resp.
- Reset mid-operation: rst pulsed for 1 cycle during MEM → mem_read = 0 the next cycle. No resp is issued. The next simultaneous request grants D.
- Spurious mem_resp in IDLE with no requests → no resp asserted; state stays IDLE.
